// File: rtl/mmio_timer_pkg.sv
// Shared constants for the MMIO machine timer: register indices, AXI response
// codes, responder states and CTRL bit positions.
package mmio_timer_pkg;

    // Register word indices (byte offset >> 2)
    localparam logic [2:0] REG_CTRL      = 3'd0;  // 0x00
    localparam logic [2:0] REG_STATUS    = 3'd1;  // 0x04
    localparam logic [2:0] REG_MTIME_LO  = 3'd2;  // 0x08
    localparam logic [2:0] REG_MTIME_HI  = 3'd3;  // 0x0C
    localparam logic [2:0] REG_CMP_LO    = 3'd4;  // 0x10
    localparam logic [2:0] REG_CMP_HI    = 3'd5;  // 0x14
    localparam int         NUM_REGS      = 6;     // offsets >= 0x18 unmapped

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    localparam int CTRL_EN = 0;
    localparam int CTRL_IE = 1;

    typedef enum logic [1:0] {IDLE, WRESP, RRESP} state_t;

    // Byte-strobe merge of new data over an old word
    function automatic logic [31:0] merge_bytes(input logic [31:0] old,
                                                input logic [31:0] data,
                                                input logic [3:0]  strb);
        logic [31:0] res;
        res = old;
        for (int b = 0; b < 4; b++)
            if (strb[b]) res[b*8 +: 8] = data[b*8 +: 8];
        return res;
    endfunction

endpackage

// File: rtl/mmio_timer_if.sv
// AXI4-Lite bus bundle between the CPU mmio port (master) and the timer (slave).
interface mmio_timer_if #(parameter int ADDR_WIDTH = 12);
    logic                  aw_valid, aw_ready;
    logic [ADDR_WIDTH-1:0] aw_bits_addr;
    logic [2:0]            aw_bits_prot;
    logic                  w_valid, w_ready;
    logic [31:0]           w_bits_data;
    logic [3:0]            w_bits_strb;
    logic                  b_valid, b_ready;
    logic [1:0]            b_bits_resp;
    logic                  ar_valid, ar_ready;
    logic [ADDR_WIDTH-1:0] ar_bits_addr;
    logic [2:0]            ar_bits_prot;
    logic                  r_valid, r_ready;
    logic [31:0]           r_bits_data;
    logic [1:0]            r_bits_resp;

    modport slave (
        input  aw_valid, aw_bits_addr, aw_bits_prot, w_valid, w_bits_data, w_bits_strb,
               b_ready, ar_valid, ar_bits_addr, ar_bits_prot, r_ready,
        output aw_ready, w_ready, b_valid, b_bits_resp, ar_ready, r_valid,
               r_bits_data, r_bits_resp
    );

    modport master (
        output aw_valid, aw_bits_addr, aw_bits_prot, w_valid, w_bits_data, w_bits_strb,
               b_ready, ar_valid, ar_bits_addr, ar_bits_prot, r_ready,
        input  aw_ready, w_ready, b_valid, b_bits_resp, ar_ready, r_valid,
               r_bits_data, r_bits_resp
    );
endinterface

// File: rtl/mmio_timer_core.sv
// Timer state: prescaler, 64-bit mtime, mtimecmp, CTRL bits and sticky pending,
// updated through a single byte-strobed register write port.
module mmio_timer_core
    import mmio_timer_pkg::*;
#(
    parameter int PRESCALE = 1
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        wr_en,
    input  logic [2:0]  wr_sel,
    input  logic [31:0] wr_data,
    input  logic [3:0]  wr_strb,
    output logic        en,
    output logic        ie,
    output logic        pending,
    output logic [63:0] mtime,
    output logic [63:0] mtimecmp
);
    localparam int PS_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

    logic [PS_W-1:0] ps_cnt;
    logic            tick;
    logic [63:0]     mtime_inc, mtime_next, cmp_next;
    logic            pend_set, pend_clr;

    assign tick      = en && (ps_cnt == PS_W'(PRESCALE - 1));
    assign mtime_inc = tick ? mtime + 64'd1 : mtime;
    assign pend_set  = (mtime >= mtimecmp);
    assign pend_clr  = wr_en && (wr_sel == REG_STATUS) && wr_strb[0] && wr_data[0];

    // Written bytes override the incremented count; untouched bytes keep the increment
    always_comb begin
        mtime_next = mtime_inc;
        cmp_next   = mtimecmp;
        if (wr_en) begin
            case (wr_sel)
                REG_MTIME_LO: mtime_next[31:0]  = merge_bytes(mtime_inc[31:0],  wr_data, wr_strb);
                REG_MTIME_HI: mtime_next[63:32] = merge_bytes(mtime_inc[63:32], wr_data, wr_strb);
                REG_CMP_LO:   cmp_next[31:0]    = merge_bytes(mtimecmp[31:0],   wr_data, wr_strb);
                REG_CMP_HI:   cmp_next[63:32]   = merge_bytes(mtimecmp[63:32],  wr_data, wr_strb);
                default: ;
            endcase
        end
    end

    // Prescaler runs only while enabled and restarts from zero when disabled
    always_ff @(posedge clock or posedge reset) begin
        if (reset)                 ps_cnt <= '0;
        else if (!en || tick)      ps_cnt <= '0;
        else                       ps_cnt <= ps_cnt + 1'b1;
    end

    // Counter, compare, control and sticky pending (set beats W1C)
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            mtime    <= '0;
            mtimecmp <= '1;
            en       <= 1'b0;
            ie       <= 1'b0;
            pending  <= 1'b0;
        end else begin
            mtime    <= mtime_next;
            mtimecmp <= cmp_next;
            pending  <= pend_set | (pending & ~pend_clr);
            if (wr_en && (wr_sel == REG_CTRL) && wr_strb[0]) begin
                en <= wr_data[CTRL_EN];
                ie <= wr_data[CTRL_IE];
            end
        end
    end
endmodule

// File: rtl/mmio_timer.sv
// AXI4-Lite responder for the machine timer: one transaction at a time,
// writes prioritised over reads, OKAY for mapped words and SLVERR otherwise.
module mmio_timer
    import mmio_timer_pkg::*;
#(
    parameter int ADDR_WIDTH = 12,
    parameter int PRESCALE   = 1
) (
    input  logic        clock,
    input  logic        reset,
    mmio_timer_if.slave io,
    output logic        io_irq
);
    state_t                state, state_next;
    logic                  aw_held, w_held;
    logic [ADDR_WIDTH-1:0] aw_addr_q;
    logic [31:0]           w_data_q;
    logic [3:0]            w_strb_q;
    logic [1:0]            b_resp_q, r_resp_q;
    logic [31:0]           r_data_q;

    logic                  aw_hs, w_hs, ar_hs, wr_fire;
    logic [ADDR_WIDTH-1:0] wr_addr;
    logic [31:0]           wr_data, rd_data;
    logic [3:0]            wr_strb;
    logic                  wr_mapped, rd_mapped;
    logic                  en, ie, pending;
    logic [63:0]           mtime, mtimecmp;

    assign io.aw_ready = (state == IDLE) && !aw_held;
    assign io.w_ready  = (state == IDLE) && !w_held;
    assign io.ar_ready = (state == IDLE) && !aw_held && !w_held && !io.aw_valid && !io.w_valid;
    assign io.b_valid     = (state == WRESP);
    assign io.b_bits_resp = b_resp_q;
    assign io.r_valid     = (state == RRESP);
    assign io.r_bits_data = r_data_q;
    assign io.r_bits_resp = r_resp_q;
    assign io_irq         = pending & ie;

    assign aw_hs   = io.aw_valid && io.aw_ready;
    assign w_hs    = io.w_valid && io.w_ready;
    assign ar_hs   = io.ar_valid && io.ar_ready;
    assign wr_fire = (state == IDLE) && (aw_held || aw_hs) && (w_held || w_hs);
    assign wr_addr = aw_held ? aw_addr_q : io.aw_bits_addr;
    assign wr_data = w_held ? w_data_q : io.w_bits_data;
    assign wr_strb = w_held ? w_strb_q : io.w_bits_strb;

    assign wr_mapped = (wr_addr[ADDR_WIDTH-1:2] < NUM_REGS);
    assign rd_mapped = (io.ar_bits_addr[ADDR_WIDTH-1:2] < NUM_REGS);

    // prot and the byte lane within a word carry no meaning here
    logic unused_ok;
    assign unused_ok = ^{io.aw_bits_prot, io.ar_bits_prot, wr_addr[1:0], io.ar_bits_addr[1:0]};

    mmio_timer_core #(.PRESCALE(PRESCALE)) core (
        .clock    (clock),
        .reset    (reset),
        .wr_en    (wr_fire && wr_mapped),
        .wr_sel   (wr_addr[4:2]),
        .wr_data  (wr_data),
        .wr_strb  (wr_strb),
        .en       (en),
        .ie       (ie),
        .pending  (pending),
        .mtime    (mtime),
        .mtimecmp (mtimecmp)
    );

    // Read mux over current register values; unmapped reads return 0
    always_comb begin
        rd_data = '0;
        if (rd_mapped) begin
            case (io.ar_bits_addr[4:2])
                REG_CTRL:     rd_data = {30'd0, ie, en};
                REG_STATUS:   rd_data = {31'd0, pending};
                REG_MTIME_LO: rd_data = mtime[31:0];
                REG_MTIME_HI: rd_data = mtime[63:32];
                REG_CMP_LO:   rd_data = mtimecmp[31:0];
                REG_CMP_HI:   rd_data = mtimecmp[63:32];
                default:      rd_data = '0;
            endcase
        end
    end

    // Next-state: write commit, read capture, response handshakes
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (wr_fire) state_next = WRESP;
                     else if (ar_hs) state_next = RRESP;
            WRESP:   if (io.b_ready) state_next = IDLE;
            RRESP:   if (io.r_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // State register plus AW/W holding flops and response payloads
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            aw_held   <= 1'b0;
            w_held    <= 1'b0;
            aw_addr_q <= '0;
            w_data_q  <= '0;
            w_strb_q  <= '0;
            b_resp_q  <= RESP_OKAY;
            r_resp_q  <= RESP_OKAY;
            r_data_q  <= '0;
        end else begin
            state <= state_next;
            if (wr_fire) begin
                aw_held  <= 1'b0;
                w_held   <= 1'b0;
                b_resp_q <= wr_mapped ? RESP_OKAY : RESP_SLVERR;
            end else begin
                if (aw_hs) begin
                    aw_held   <= 1'b1;
                    aw_addr_q <= io.aw_bits_addr;
                end
                if (w_hs) begin
                    w_held   <= 1'b1;
                    w_data_q <= io.w_bits_data;
                    w_strb_q <= io.w_bits_strb;
                end
            end
            if (ar_hs) begin
                r_data_q <= rd_data;
                r_resp_q <= rd_mapped ? RESP_OKAY : RESP_SLVERR;
            end
        end
    end
endmodule
